// File: rtl/spbram_rmw_port.sv
`default_nettype none
// ============================================================================
// Module   : spbram_rmw_port
// Purpose  : Valid/ready front-end for a single-port BRAM adding byte masks
//            via internal read-modify-write.
// Revision : 1.0
// ============================================================================
module spbram_rmw_port #(
    parameter int ADDRESS_BITWIDTH = 16,
    parameter int DATA_BITWIDTH    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ADDRESS_BITWIDTH-1:0] req_address,
    input  logic [3:0]                  req_write_mask,
    input  logic [DATA_BITWIDTH-1:0]    req_data,
    output logic                        rsp_valid,
    output logic [DATA_BITWIDTH-1:0]    rsp_data,
    output logic                        bram_write_enable,
    output logic [ADDRESS_BITWIDTH-1:0] bram_address,
    output logic [DATA_BITWIDTH-1:0]    bram_data_out,
    input  logic [DATA_BITWIDTH-1:0]    bram_data_in
);

    localparam int c_LANES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DATA  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [3:0]                    r_mask;
    logic [3:0]                    w_mask_nxt;
    logic [DATA_BITWIDTH-1:0]      r_data;
    logic [DATA_BITWIDTH-1:0]      w_data_nxt;
    logic                          r_rsp_valid;
    logic                          w_rsp_valid_nxt;
    logic [DATA_BITWIDTH-1:0]      r_rsp_data;
    logic [DATA_BITWIDTH-1:0]      w_rsp_data_nxt;
    logic                          r_bram_we;
    logic                          w_bram_we_nxt;
    logic [ADDRESS_BITWIDTH-1:0]   r_bram_addr;
    logic [ADDRESS_BITWIDTH-1:0]   w_bram_addr_nxt;
    logic [DATA_BITWIDTH-1:0]      r_bram_dout;
    logic [DATA_BITWIDTH-1:0]      w_bram_dout_nxt;
    logic [DATA_BITWIDTH-1:0]      w_merged;

    // Masked lanes take the new data, the rest keep the word read back.
    for (genvar n = 0; n < c_LANES; n++) begin : g_lane
        assign w_merged[8*n +: 8] = r_mask[n] ? r_data[8*n +: 8] : bram_data_in[8*n +: 8];
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_mask_nxt      = r_mask;
        w_data_nxt      = r_data;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_data_nxt  = r_rsp_data;
        w_bram_we_nxt   = 1'b0;
        w_bram_addr_nxt = r_bram_addr;
        w_bram_dout_nxt = r_bram_dout;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_mask_nxt      = req_write_mask;
                    w_data_nxt      = req_data;
                    w_bram_addr_nxt = req_address;
                    if (req_write_mask == 4'hF) begin
                        w_bram_dout_nxt = req_data;
                        w_bram_we_nxt   = 1'b1;
                        w_state_nxt     = WRITE;
                    end else begin
                        w_state_nxt = READ;
                    end
                end
            end
            READ: begin
                w_state_nxt = DATA;
            end
            DATA: begin
                if (r_mask == 4'h0) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = bram_data_in;
                    w_state_nxt     = IDLE;
                end else begin
                    w_bram_dout_nxt = w_merged;
                    w_bram_we_nxt   = 1'b1;
                    w_state_nxt     = WRITE;
                end
            end
            WRITE: begin
                w_rsp_valid_nxt = 1'b1;
                w_rsp_data_nxt  = r_bram_dout;
                w_state_nxt     = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mask      <= 4'h0;
            r_data      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_bram_we   <= 1'b0;
            r_bram_addr <= '0;
            r_bram_dout <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mask      <= w_mask_nxt;
            r_data      <= w_data_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_bram_we   <= w_bram_we_nxt;
            r_bram_addr <= w_bram_addr_nxt;
            r_bram_dout <= w_bram_dout_nxt;
        end
    end

    assign req_ready         = (r_state == IDLE) && !rst;
    assign rsp_valid         = r_rsp_valid;
    assign rsp_data          = r_rsp_data;
    assign bram_write_enable = r_bram_we;
    assign bram_address      = r_bram_addr;
    assign bram_data_out     = r_bram_dout;

endmodule
`default_nettype wire

// File: tb/tb_spbram_rmw_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_spbram_rmw_port
// Purpose  : Directed and mixed-traffic checks of spbram_rmw_port with a
//            behavioural read-before-write BRAM attached.
// Revision : 1.0
// ============================================================================
module tb_spbram_rmw_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_address;
    logic [3:0]  req_write_mask;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        bram_write_enable;
    logic [15:0] bram_address;
    logic [31:0] bram_data_out;
    logic [31:0] bram_data_in;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic [15:0] we_addr;

    always #5 clk = ~clk;

    spbram_rmw_port #(.ADDRESS_BITWIDTH(16), .DATA_BITWIDTH(32)) u_dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_address       (req_address),
        .req_write_mask    (req_write_mask),
        .req_data          (req_data),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .bram_write_enable (bram_write_enable),
        .bram_address      (bram_address),
        .bram_data_out     (bram_data_out),
        .bram_data_in      (bram_data_in)
    );

    // Single-port BRAM: registered read, old word returned on a write.
    always @(posedge clk) begin
        if (bram_write_enable) mem[bram_address[7:0]] <= bram_data_out;
        bram_data_in <= mem[bram_address[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; presents a request for the next rising edge.
    task automatic issue(input logic [15:0] addr, input logic [3:0] mask, input logic [31:0] data);
        req_valid      = 1'b1;
        req_address    = addr;
        req_write_mask = mask;
        req_data       = data;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    endtask

    // Waits for the accept edge, then samples on negedges until a response.
    task automatic wait_rsp(input bit hold, output logic [31:0] data, output int lat, output int wes);
        lat = -1; wes = 0; data = '0;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
            if (bram_write_enable) begin
                wes++;
                we_addr = bram_address;
            end
            if (rsp_valid) begin
                lat  = k;
                data = rsp_data;
                break;
            end
            check("req_ready_busy", {31'd0, req_ready}, 32'd0);
        end
    endtask

    logic [31:0] d;
    int          lat;
    int          wes;
    int          cnt;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'd0;
            ref_mem[i] = 32'd0;
        end
        rst = 1'b1; req_valid = 1'b1; req_address = 16'h0033;
        req_write_mask = 4'hF; req_data = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        check("rst_ready",     {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data",  rsp_data, 32'd0);
        check("rst_we",        {31'd0, bram_write_enable}, 32'd0);
        check("rst_addr",      {16'd0, bram_address}, 32'd0);
        check("rst_dout",      bram_data_out, 32'd0);
        req_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("post_rst_we", {31'd0, bram_write_enable}, 32'd0);

        // Full write
        issue(16'h0010, 4'hF, 32'hDEADBEEF);
        wait_rsp(1'b0, d, lat, wes);
        check("fw_lat",  lat, 32'd1);
        check("fw_data", d, 32'hDEADBEEF);
        check("fw_wes",  wes, 32'd1);
        check("fw_addr", {16'd0, we_addr}, 32'h0010);

        // Read
        issue(16'h0010, 4'h0, 32'h0);
        wait_rsp(1'b0, d, lat, wes);
        check("rd_lat",  lat, 32'd2);
        check("rd_data", d, 32'hDEADBEEF);
        check("rd_wes",  wes, 32'd0);

        // Partial write, low two lanes
        issue(16'h0010, 4'b0011, 32'h000055AA);
        wait_rsp(1'b0, d, lat, wes);
        check("pw_lat",  lat, 32'd3);
        check("pw_data", d, 32'hDEAD55AA);
        check("pw_wes",  wes, 32'd1);
        issue(16'h0010, 4'h0, 32'h0);
        wait_rsp(1'b0, d, lat, wes);
        check("pw_rd", d, 32'hDEAD55AA);

        // Top lane write with valid held, read issued in the response cycle
        issue(16'h0010, 4'b1000, 32'h12000000);
        wait_rsp(1'b1, d, lat, wes);
        check("b2b_w_lat",  lat, 32'd3);
        check("b2b_w_data", d, 32'h12AD55AA);
        issue(16'h0010, 4'h0, 32'hFFFFFFFF);
        wait_rsp(1'b0, d, lat, wes);
        check("b2b_r_lat",  lat, 32'd2);
        check("b2b_r_data", d, 32'h12AD55AA);
        check("b2b_r_wes",  wes, 32'd0);

        // Reset during DATA of a partial write aborts it
        issue(16'h0020, 4'hF, 32'h11111111);
        wait_rsp(1'b0, d, lat, wes);
        check("pre_data", d, 32'h11111111);
        issue(16'h0020, 4'b0011, 32'hAAAAAAAA);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        @(negedge clk);
        check("abort_ready_rst", {31'd0, req_ready}, 32'd0);
        if (bram_write_enable || rsp_valid) cnt++;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bram_write_enable || rsp_valid) cnt++;
        end
        check("abort_quiet", cnt, 32'd0);
        issue(16'h0020, 4'h0, 32'h0);
        wait_rsp(1'b0, d, lat, wes);
        check("abort_rd", d, 32'h11111111);

        // Mixed traffic against a reference memory
        ref_mem[8'h10] = 32'h12AD55AA;
        ref_mem[8'h20] = 32'h11111111;
        for (int i = 0; i < 40; i++) begin
            logic [7:0]  a;
            logic [3:0]  m;
            logic [31:0] wd;
            logic [31:0] exp;
            a  = 8'($urandom_range(0, 255));
            m  = 4'($urandom_range(0, 15));
            wd = $urandom;
            exp = ref_mem[a];
            for (int b = 0; b < 4; b++)
                if (m[b]) exp[8*b +: 8] = wd[8*b +: 8];
            ref_mem[a] = exp;
            issue({8'd0, a}, m, wd);
            wait_rsp(1'b0, d, lat, wes);
            check("rnd_data", d, exp);
            check("rnd_wes", wes, (m != 4'h0) ? 32'd1 : 32'd0);
            check("rnd_lat", lat, (m == 4'h0) ? 32'd2 : ((m == 4'hF) ? 32'd1 : 32'd3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
